// File: rtl/jtag_pkg.sv
// Shared JTAG definitions for the user-logic endpoints and their benches.
// Holds the IR encoding, the default widths and the TAP state names.
package jtag_pkg;
    localparam int IR_LEN = 6;
    localparam logic [IR_LEN-1:0] IR_USER4 = 6'h23;
    localparam int RESULT_WIDTH_DEF = 32;
    localparam int COUNT_WIDTH_DEF = 16;

    typedef enum logic [3:0] {
        TAP_TEST_LOGIC_RESET,
        TAP_RUN_TEST_IDLE,
        TAP_SELECT_DR,
        TAP_CAPTURE_DR,
        TAP_SHIFT_DR,
        TAP_EXIT1_DR,
        TAP_PAUSE_DR,
        TAP_EXIT2_DR,
        TAP_UPDATE_DR,
        TAP_SELECT_IR,
        TAP_CAPTURE_IR,
        TAP_SHIFT_IR,
        TAP_EXIT1_IR,
        TAP_PAUSE_IR,
        TAP_EXIT2_IR,
        TAP_UPDATE_IR
    } state_t;
endpackage

// File: rtl/tdi_byte_deserializer.sv
// Collects TDI bits LSB first into bytes and flags a partial byte left over at update.
// Control inputs arrive already qualified and mutually exclusive.
module tdi_byte_deserializer (
    input  logic       tck,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       shift,
    input  logic       update,
    input  logic       tdi,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       byte_done,
    output logic       trunc
);
    logic [7:0] sreg_q, sreg_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] byte_data_q, byte_data_d;
    logic       byte_valid_q, byte_valid_d;
    logic       trunc_q, trunc_d;

    always_comb begin
        sreg_d       = sreg_q;
        bit_cnt_d    = bit_cnt_q;
        byte_data_d  = byte_data_q;
        byte_valid_d = 1'b0;
        trunc_d      = 1'b0;
        byte_done    = 1'b0;
        if (clr) begin
            sreg_d    = 8'h00;
            bit_cnt_d = 3'd0;
        end else if (shift) begin
            sreg_d    = {tdi, sreg_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                byte_done    = 1'b1;
                byte_data_d  = {tdi, sreg_q[7:1]};
                byte_valid_d = 1'b1;
            end
        end else if (update) begin
            trunc_d   = (bit_cnt_q != 3'd0);
            bit_cnt_d = 3'd0;
        end
    end

    always_ff @(posedge tck or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q       <= 8'h00;
            bit_cnt_q    <= 3'd0;
            byte_data_q  <= 8'h00;
            byte_valid_q <= 1'b0;
            trunc_q      <= 1'b0;
        end else begin
            sreg_q       <= sreg_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_data_q  <= byte_data_d;
            byte_valid_q <= byte_valid_d;
            trunc_q      <= trunc_d;
        end
    end

    assign byte_data  = byte_data_q;
    assign byte_valid = byte_valid_q;
    assign trunc      = trunc_q;
endmodule

// File: rtl/jtag_byte_receiver.sv
// USER4 data-register endpoint: bytes in from TDI, result word out on TDO.
// Capture wins over shift, shift wins over update when they overlap.
module jtag_byte_receiver
    import jtag_pkg::*;
#(
    parameter int RESULT_WIDTH = RESULT_WIDTH_DEF,
    parameter int COUNT_WIDTH  = COUNT_WIDTH_DEF
) (
    input  logic                    tck,
    input  logic                    rst_n,
    input  logic                    ir_is_user,
    input  logic                    capture_dr,
    input  logic                    shift_dr,
    input  logic                    update_dr,
    input  logic                    tdi,
    output logic                    tdo,
    input  logic [RESULT_WIDTH-1:0] result,
    output logic [7:0]              byte_data,
    output logic                    byte_valid,
    output logic [COUNT_WIDTH-1:0]  byte_count,
    output logic                    scan_end,
    output logic                    scan_trunc
);
    logic cap_en, shift_en, upd_en, byte_done;

    logic [RESULT_WIDTH-1:0] result_sr_q, result_sr_d;
    logic [COUNT_WIDTH-1:0]  byte_count_q, byte_count_d;
    logic                    scan_end_q, scan_end_d;

    assign cap_en   = ir_is_user & capture_dr;
    assign shift_en = ir_is_user & shift_dr & ~capture_dr;
    assign upd_en   = ir_is_user & update_dr & ~capture_dr & ~shift_dr;

    tdi_byte_deserializer u_deser (
        .tck        (tck),
        .rst_n      (rst_n),
        .clr        (cap_en),
        .shift      (shift_en),
        .update     (upd_en),
        .tdi        (tdi),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_done  (byte_done),
        .trunc      (scan_trunc)
    );

    always_comb begin
        result_sr_d  = result_sr_q;
        byte_count_d = byte_count_q;
        scan_end_d   = 1'b0;
        if (cap_en) begin
            result_sr_d  = result;
            byte_count_d = '0;
        end else if (shift_en) begin
            result_sr_d = {1'b0, result_sr_q[RESULT_WIDTH-1:1]};
            // Saturate so a very long scan never wraps back to a small count.
            if (byte_done && (byte_count_q != '1)) begin
                byte_count_d = byte_count_q + 1'b1;
            end
        end else if (upd_en) begin
            scan_end_d = 1'b1;
        end
    end

    always_ff @(posedge tck or negedge rst_n) begin
        if (!rst_n) begin
            result_sr_q  <= '0;
            byte_count_q <= '0;
            scan_end_q   <= 1'b0;
        end else begin
            result_sr_q  <= result_sr_d;
            byte_count_q <= byte_count_d;
            scan_end_q   <= scan_end_d;
        end
    end

    // BSCANE2 samples TDO on falling tck, half a cycle after the shift edge.
    assign tdo        = result_sr_q[0];
    assign byte_count = byte_count_q;
    assign scan_end   = scan_end_q;
endmodule

// File: tb/tb_jtag_byte_receiver.sv
// Scoreboard bench for jtag_byte_receiver: directed scans plus random scans.
// The driver pushes expected bytes/scan ends; a monitor pops and compares.
module tb_jtag_byte_receiver;
    import jtag_pkg::*;

    localparam int RW = 32;
    localparam int CW = 16;

    logic          tck = 1'b0;
    logic          rst_n = 1'b0;
    logic          ir_is_user = 1'b0;
    logic          capture_dr = 1'b0;
    logic          shift_dr = 1'b0;
    logic          update_dr = 1'b0;
    logic          tdi = 1'b0;
    logic [RW-1:0] result = '0;
    logic          tdo;
    logic [7:0]    byte_data;
    logic          byte_valid;
    logic [CW-1:0] byte_count;
    logic          scan_end;
    logic          scan_trunc;

    jtag_byte_receiver #(.RESULT_WIDTH(RW), .COUNT_WIDTH(CW)) dut (
        .tck        (tck),
        .rst_n      (rst_n),
        .ir_is_user (ir_is_user),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr),
        .tdi        (tdi),
        .tdo        (tdo),
        .result     (result),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_count (byte_count),
        .scan_end   (scan_end),
        .scan_trunc (scan_trunc)
    );

    always #5 tck = ~tck;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0]    data;
        logic [CW-1:0] count;
    } byte_exp_t;

    byte_exp_t     byte_q[$];
    logic          scan_q[$];
    logic [CW-1:0] mcount = '0;
    byte_exp_t     mon_e;
    logic          mon_t;
    logic [7:0]    last_byte = 8'h00;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a pulse.
    initial begin
        forever begin
            @(posedge tck);
            #1;
            if (!rst_n) begin
                last_byte = 8'h00;
                continue;
            end
            if (byte_valid) begin
                if (byte_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got 0x%0h expected none", byte_data);
                end else begin
                    mon_e = byte_q.pop_front();
                    check("byte_data", 64'(byte_data), 64'(mon_e.data));
                    check("byte_count", 64'(byte_count), 64'(mon_e.count));
                    last_byte = mon_e.data;
                end
            end else begin
                check("byte_data_hold", 64'(byte_data), 64'(last_byte));
            end
            if (scan_end) begin
                if (scan_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_scan_end: got 1 expected 0");
                end else begin
                    mon_t = scan_q.pop_front();
                    check("scan_trunc", 64'(scan_trunc), 64'(mon_t));
                end
            end else if (scan_trunc) begin
                n_checks++;
                n_fail++;
                $display("FAIL trunc_without_end: got 1 expected 0");
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_tdo"}, 64'(tdo), 64'd0);
        check({tag, "_byte_data"}, 64'(byte_data), 64'd0);
        check({tag, "_byte_valid"}, 64'(byte_valid), 64'd0);
        check({tag, "_byte_count"}, 64'(byte_count), 64'd0);
        check({tag, "_scan_end"}, 64'(scan_end), 64'd0);
        check({tag, "_scan_trunc"}, 64'(scan_trunc), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge tck);
        #2;
        rst_n = 1'b0;
        capture_dr = 1'b0;
        shift_dr = 1'b0;
        update_dr = 1'b0;
        #1;
        check_all_zero("reset");
        mcount = '0;
        repeat (2) @(negedge tck);
        rst_n = 1'b1;
    endtask

    // Reference: byte k of a scan is bits[8k+7:8k]; tdo after i shifts is res[i] or 0.
    task automatic run_scan(input logic [63:0] bits, input int nbits,
                            input logic [RW-1:0] res, input bit user);
        @(negedge tck);
        ir_is_user = user;
        capture_dr = 1'b1;
        result = res;
        if (user) mcount = '0;
        for (int i = 0; i < nbits; i++) begin
            @(negedge tck);
            capture_dr = 1'b0;
            shift_dr = 1'b1;
            tdi = bits[i];
            if (user) check("tdo", 64'(tdo), (i < RW) ? 64'(res[i]) : 64'd0);
            if (user && (i % 8 == 7)) begin
                if (mcount != '1) mcount = mcount + 1'b1;
                byte_q.push_back('{data: bits[i-7 +: 8], count: mcount});
            end
        end
        @(negedge tck);
        capture_dr = 1'b0;
        shift_dr = 1'b0;
        update_dr = 1'b1;
        if (user) scan_q.push_back((nbits % 8) != 0);
        @(negedge tck);
        update_dr = 1'b0;
        ir_is_user = 1'b0;
        @(negedge tck);
        check("byte_count_after_scan", 64'(byte_count), 64'(mcount));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rbits;
        repeat (3) @(negedge tck);
        #1;
        check_all_zero("initial_reset");
        rst_n = 1'b1;

        run_scan(64'h41, 8, 32'h1234_5678, 1'b1);
        run_scan(64'h32_0A_31, 24, 32'hCAFE_F00D, 1'b1);
        run_scan(64'h5AB, 12, 32'h0000_0001, 1'b1);
        run_scan(64'h7E, 8, 32'h8000_0000, 1'b1);
        rbits = {$urandom, $urandom};
        run_scan(rbits, 40, 32'hDEAD_BEEF, 1'b1);

        do_reset();
        run_scan(64'hA55A, 16, 32'hFFFF_FFFF, 1'b0);

        // Reset in the middle of a byte discards the partial bits.
        @(negedge tck);
        ir_is_user = 1'b1;
        capture_dr = 1'b1;
        result = 32'h0F0F_0F0F;
        for (int i = 0; i < 5; i++) begin
            @(negedge tck);
            capture_dr = 1'b0;
            shift_dr = 1'b1;
            tdi = i[0];
        end
        do_reset();
        ir_is_user = 1'b0;
        run_scan(64'hC3, 8, 32'h2468_ACE0, 1'b1);

        for (int s = 0; s < 14; s++) begin
            rbits = {$urandom, $urandom};
            run_scan(rbits, $urandom_range(0, 48), $urandom, $urandom_range(0, 4) != 0);
        end

        repeat (4) @(negedge tck);
        check("byte_q_drained", 64'(byte_q.size()), 64'd0);
        check("scan_q_drained", 64'(scan_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
